// File: rtl/set_ctrl_pkg.sv
// Shared types and circle-word width helpers for the set controller, MapCell and candidate adder.
package set_ctrl_pkg;

   typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

   localparam int unsigned DefCoordW = 4;
   localparam int unsigned DefRadW   = 4;

   // Circle word is {x, y, radius}.
   function automatic int unsigned circ_w(input int unsigned coord_w, input int unsigned rad_w);
      return 2 * coord_w + rad_w;
   endfunction

   localparam int unsigned DefCircW = circ_w(DefCoordW, DefRadW);

endpackage

// File: rtl/set_ctrl_if.sv
// Job request / item presentation bundle for set_ctrl_n.
// cand_ready exists only when SET_CTRL_STALL_EN is defined.
interface set_ctrl_if #(
   parameter int unsigned NUM_CIRCLES = 3,
   parameter int unsigned ROWS        = 8,
   parameter int unsigned COORD_W     = 4,
   parameter int unsigned RAD_W       = 4
);
   import set_ctrl_pkg::*;

   localparam int unsigned CIRC_W = circ_w(COORD_W, RAD_W);
   localparam int unsigned ROW_W  = $clog2(ROWS);
   localparam int unsigned IDX_W  = $clog2(NUM_CIRCLES);

   logic                             en;
   logic [NUM_CIRCLES*2*COORD_W-1:0] central;
   logic [NUM_CIRCLES*RAD_W-1:0]     radius;
   logic [NUM_CIRCLES-1:0]           circle_mask;
`ifdef SET_CTRL_STALL_EN
   logic                             cand_ready;
`endif
   logic                             busy;
   logic                             valid;
   logic [ROW_W-1:0]                 row_id;
   logic [IDX_W-1:0]                 circle_idx;
   logic [CIRC_W-1:0]                circle_data;
   logic                             cand_en;
   logic                             row_last;
   logic [NUM_CIRCLES-1:0]           reg_mask;

`ifdef SET_CTRL_STALL_EN
   modport master (
      output en, central, radius, circle_mask, cand_ready,
      input  busy, valid, row_id, circle_idx, circle_data, cand_en, row_last, reg_mask
   );
   modport slave (
      input  en, central, radius, circle_mask, cand_ready,
      output busy, valid, row_id, circle_idx, circle_data, cand_en, row_last, reg_mask
   );
`else
   modport master (
      output en, central, radius, circle_mask,
      input  busy, valid, row_id, circle_idx, circle_data, cand_en, row_last, reg_mask
   );
   modport slave (
      input  en, central, radius, circle_mask,
      output busy, valid, row_id, circle_idx, circle_data, cand_en, row_last, reg_mask
   );
`endif

endinterface

// File: rtl/set_ctrl_next_sel.sv
// Combinational circle selector: next set mask bit above idx, wrap flag, lowest set bit.
module set_ctrl_next_sel #(
   parameter int unsigned NUM_CIRCLES = 3,
   localparam int unsigned IdxW       = $clog2(NUM_CIRCLES)
) (
   input  logic [NUM_CIRCLES-1:0] mask,
   input  logic [IdxW-1:0]        idx,
   output logic [IdxW-1:0]        next_idx,
   output logic                   wrap,
   output logic [IdxW-1:0]        low_idx
);

   // Descending scan so the final hit is the lowest qualifying bit.
   always_comb begin
      next_idx = '0;
      wrap     = 1'b1;
      low_idx  = '0;
      for (int i = NUM_CIRCLES - 1; i >= 0; i--) begin
         if (mask[i]) begin
            low_idx = IdxW'(i);
         end
         if (mask[i] && (i > int'(idx))) begin
            next_idx = IdxW'(i);
            wrap     = 1'b0;
         end
      end
   end

endmodule

// File: rtl/set_ctrl_n.sv
// Row-major scanner presenting each (row, selected circle) pair to the candidate adder.
// Define SET_CTRL_STALL_EN to add the cand_ready back-pressure input.
module set_ctrl_n
   import set_ctrl_pkg::*;
#(
   parameter int unsigned NUM_CIRCLES = 3,
   parameter int unsigned ROWS        = 8,
   parameter int unsigned COORD_W     = 4,
   parameter int unsigned RAD_W       = 4
) (
   input  logic       clk,
   input  logic       rst,
   set_ctrl_if.slave  bus
);

   localparam int unsigned CIRC_W = circ_w(COORD_W, RAD_W);
   localparam int unsigned CENT_W = 2 * COORD_W;
   localparam int unsigned ROW_W  = $clog2(ROWS);
   localparam int unsigned IDX_W  = $clog2(NUM_CIRCLES);
   localparam logic [ROW_W-1:0] LastRow = ROW_W'(ROWS - 1);

   state_e                          state_q, state_d;
   logic [NUM_CIRCLES*CENT_W-1:0]   cent_q, cent_d;
   logic [NUM_CIRCLES*RAD_W-1:0]    rad_q, rad_d;
   logic [NUM_CIRCLES-1:0]          mask_q, mask_d;
   logic [IDX_W-1:0]                hi_q, hi_d;
   logic [ROW_W-1:0]                row_q, row_d;
   logic [IDX_W-1:0]                idx_q, idx_d;
   logic [CIRC_W-1:0]               data_q, data_d;
   logic                            busy_q, busy_d, valid_q, valid_d;
   logic                            cand_en_q, cand_en_d, row_last_q, row_last_d;

   logic                            ready;
   logic [NUM_CIRCLES-1:0]          sel_mask;
   logic [IDX_W-1:0]                next_idx, low_idx, in_hi;
   logic                            wrap;

`ifdef SET_CTRL_STALL_EN
   assign ready = bus.cand_ready;
`else
   assign ready = 1'b1;
`endif

   // In IDLE the selector looks at the incoming mask so row 0 is ready at the accept edge.
   assign sel_mask = (state_q == StIdle) ? bus.circle_mask : mask_q;

   set_ctrl_next_sel #(
      .NUM_CIRCLES (NUM_CIRCLES)
   ) u_next_sel (
      .mask     (sel_mask),
      .idx      (idx_q),
      .next_idx (next_idx),
      .wrap     (wrap),
      .low_idx  (low_idx)
   );

   always_comb begin
      in_hi = '0;
      for (int i = 0; i < NUM_CIRCLES; i++) begin
         if (bus.circle_mask[i]) in_hi = IDX_W'(i);
      end
   end

   // Circle 0 lives in the most-significant slice.
   function automatic logic [CIRC_W-1:0] pick(input logic [NUM_CIRCLES*CENT_W-1:0] cent,
                                              input logic [NUM_CIRCLES*RAD_W-1:0]  rad,
                                              input logic [IDX_W-1:0]              i);
      int s;
      s = int'(NUM_CIRCLES) - 1 - int'(i);
      if (s < 0) s = 0;
      return {cent[s*int'(CENT_W) +: CENT_W], rad[s*int'(RAD_W) +: RAD_W]};
   endfunction

   always_comb begin
      state_d    = state_q;
      cent_d     = cent_q;
      rad_d      = rad_q;
      mask_d     = mask_q;
      hi_d       = hi_q;
      row_d      = row_q;
      idx_d      = idx_q;
      data_d     = data_q;
      row_last_d = row_last_q;
      busy_d     = 1'b0;
      valid_d    = 1'b0;
      cand_en_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.en) begin
               cent_d = bus.central;
               rad_d  = bus.radius;
               mask_d = bus.circle_mask;
               hi_d   = in_hi;
               if (bus.circle_mask == '0) begin
                  state_d = StDone;
                  valid_d = 1'b1;
               end else begin
                  state_d    = StScan;
                  busy_d     = 1'b1;
                  cand_en_d  = 1'b1;
                  row_d      = '0;
                  idx_d      = low_idx;
                  data_d     = pick(bus.central, bus.radius, low_idx);
                  row_last_d = (low_idx == in_hi);
               end
            end
         end
         StScan: begin
            busy_d    = 1'b1;
            cand_en_d = 1'b1;
            if (ready) begin
               if (!wrap) begin
                  idx_d      = next_idx;
                  data_d     = pick(cent_q, rad_q, next_idx);
                  row_last_d = (next_idx == hi_q);
               end else if (row_q == LastRow) begin
                  state_d   = StDone;
                  busy_d    = 1'b0;
                  cand_en_d = 1'b0;
                  valid_d   = 1'b1;
               end else begin
                  row_d      = row_q + ROW_W'(1);
                  idx_d      = low_idx;
                  data_d     = pick(cent_q, rad_q, low_idx);
                  row_last_d = (low_idx == hi_q);
               end
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         cent_q     <= '0;
         rad_q      <= '0;
         mask_q     <= '0;
         hi_q       <= '0;
         row_q      <= '0;
         idx_q      <= '0;
         data_q     <= '0;
         busy_q     <= 1'b0;
         valid_q    <= 1'b0;
         cand_en_q  <= 1'b0;
         row_last_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cent_q     <= cent_d;
         rad_q      <= rad_d;
         mask_q     <= mask_d;
         hi_q       <= hi_d;
         row_q      <= row_d;
         idx_q      <= idx_d;
         data_q     <= data_d;
         busy_q     <= busy_d;
         valid_q    <= valid_d;
         cand_en_q  <= cand_en_d;
         row_last_q <= row_last_d;
      end
   end

   assign bus.busy        = busy_q;
   assign bus.valid       = valid_q;
   assign bus.row_id      = row_q;
   assign bus.circle_idx  = idx_q;
   assign bus.circle_data = data_q;
   assign bus.cand_en     = cand_en_q;
   assign bus.row_last    = row_last_q;
   assign bus.reg_mask    = mask_q;

endmodule
